// File: rtl/kyber_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | kyber_pkg: shared modulus, arithmetic-unit op codes and butterfly FSM states |
// | rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
package kyber_pkg;

   localparam logic [11:0] KYBER_Q   = 12'd3329;

   localparam logic [1:0]  MORB_MONT = 2'b10;
   localparam logic [1:0]  MORB_ADD  = 2'b01;
   localparam logic [1:0]  MORB_SUB  = 2'b00;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_MCLR = 3'd1,
      ST_MRUN = 3'd2,
      ST_ADD  = 3'd3,
      ST_SUB  = 3'd4,
      ST_OUT  = 3'd5
   } bfly_state_e;

endpackage
`default_nettype wire

// File: rtl/kyber_bfly_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | kyber_bfly_ctrl: steps one shared mod-q arithmetic unit through a CT NTT    |
// | butterfly (t=mont(zeta,b); a'=a+t; b'=a-t). rev 1.0                         |
// +----------------------------------------------------------------------------+
module kyber_bfly_ctrl
   import kyber_pkg::*;
#(
   parameter logic [11:0] KYBER_Q = kyber_pkg::KYBER_Q,
   parameter int          TIMEOUT = 8,
   parameter int          CNT_W   = 4,
   localparam int         DW      = $clog2(KYBER_Q)
) (
   input  logic          i_clk,
   input  logic          i_rst,
   input  logic          i_valid,
   output logic          o_ready,
   input  logic [DW-1:0] i_a,
   input  logic [DW-1:0] i_b,
   input  logic [DW-1:0] i_zeta,
   output logic          o_valid,
   input  logic          i_ready,
   output logic [DW-1:0] o_a,
   output logic [DW-1:0] o_b,
   output logic [DW-1:0] o_au_a,
   output logic [DW-1:0] o_au_b,
   output logic [1:0]    o_au_morb,
   output logic          o_au_rstn,
   input  logic [DW-1:0] i_au_c,
   input  logic          i_au_done,
   output logic          o_err,
   input  logic          i_err_clr
);

   bfly_state_e      state_q, state_d;
   logic [DW-1:0]    a_q, a_d;
   logic [DW-1:0]    res_a_q, res_a_d;
   logic [DW-1:0]    res_b_q, res_b_d;
   logic             valid_q, valid_d;
   logic [DW-1:0]    au_a_q, au_a_d;
   logic [DW-1:0]    au_b_q, au_b_d;
   logic [1:0]       morb_q, morb_d;
   logic             rstn_q, rstn_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             err_q, err_d;

   logic             w_settle;
   logic             w_capture;
   logic             w_expire;

   // The counter is zero exactly on the first cycle of each op, so it doubles
   // as the settle-cycle marker.
   assign w_settle  = (cnt_q == '0);
   assign w_capture = i_au_done && !w_settle;
   assign w_expire  = (cnt_q == CNT_W'(TIMEOUT - 1));

   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      res_a_d = res_a_q;
      res_b_d = res_b_q;
      valid_d = valid_q;
      au_a_d  = au_a_q;
      au_b_d  = au_b_q;
      morb_d  = morb_q;
      rstn_d  = 1'b1;
      cnt_d   = cnt_q;
      err_d   = err_q;

      unique case (state_q)
         ST_IDLE: begin
            if (i_valid) begin
               a_d     = i_a;
               au_a_d  = i_zeta;
               au_b_d  = i_b;
               morb_d  = MORB_MONT;
               rstn_d  = 1'b0;
               state_d = ST_MCLR;
            end
         end
         ST_MCLR: begin
            cnt_d   = '0;
            state_d = ST_MRUN;
         end
         ST_MRUN, ST_ADD, ST_SUB: begin
            if (w_capture) begin
               cnt_d = '0;
               if (state_q == ST_MRUN) begin
                  // t is held in the operand register; it is only needed as b of both add and sub
                  au_a_d  = a_q;
                  au_b_d  = i_au_c;
                  morb_d  = MORB_ADD;
                  state_d = ST_ADD;
               end else if (state_q == ST_ADD) begin
                  res_a_d = i_au_c;
                  morb_d  = MORB_SUB;
                  state_d = ST_SUB;
               end else begin
                  res_b_d = i_au_c;
                  valid_d = 1'b1;
                  state_d = ST_OUT;
               end
            end else if (w_expire) begin
               err_d   = 1'b1;
               rstn_d  = 1'b0;
               cnt_d   = '0;
               state_d = ST_IDLE;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         ST_OUT: begin
            if (i_ready) begin
               valid_d = 1'b0;
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      if (i_err_clr) begin
         err_d = 1'b0;
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q <= ST_IDLE;
         a_q     <= '0;
         res_a_q <= '0;
         res_b_q <= '0;
         valid_q <= 1'b0;
         au_a_q  <= '0;
         au_b_q  <= '0;
         morb_q  <= MORB_MONT;
         rstn_q  <= 1'b1;
         cnt_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         res_a_q <= res_a_d;
         res_b_q <= res_b_d;
         valid_q <= valid_d;
         au_a_q  <= au_a_d;
         au_b_q  <= au_b_d;
         morb_q  <= morb_d;
         rstn_q  <= rstn_d;
         cnt_q   <= cnt_d;
         err_q   <= err_d;
      end
   end

   assign o_ready   = (state_q == ST_IDLE);
   assign o_valid   = valid_q;
   assign o_a       = res_a_q;
   assign o_b       = res_b_q;
   assign o_au_a    = au_a_q;
   assign o_au_b    = au_b_q;
   assign o_au_morb = morb_q;
   assign o_au_rstn = rstn_q;
   assign o_err     = err_q;

endmodule
`default_nettype wire

// File: tb/tb_kyber_bfly_ctrl.sv
`default_nettype none
// Bench for kyber_bfly_ctrl: behavioural 4-phase arithmetic unit, butterfly
// scoreboard and a per-cycle output monitor, plus directed literal cases.
module tb_kyber_bfly_ctrl;

   localparam int Q   = 3329;
   localparam int TMO = 8;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        i_valid = 1'b0;
   logic        i_ready = 1'b0;
   logic        i_err_clr = 1'b0;
   logic [11:0] i_a = '0, i_b = '0, i_zeta = '0;
   logic        o_ready, o_valid, o_au_rstn, o_err;
   logic [11:0] o_a, o_b, o_au_a, o_au_b;
   logic [1:0]  o_au_morb;
   logic [11:0] au_c;
   logic        au_done;

   always #5 clk = ~clk;

   kyber_bfly_ctrl dut (
      .i_clk(clk), .i_rst(rst), .i_valid(i_valid), .o_ready(o_ready),
      .i_a(i_a), .i_b(i_b), .i_zeta(i_zeta), .o_valid(o_valid), .i_ready(i_ready),
      .o_a(o_a), .o_b(o_b), .o_au_a(o_au_a), .o_au_b(o_au_b), .o_au_morb(o_au_morb),
      .o_au_rstn(o_au_rstn), .i_au_c(au_c), .i_au_done(au_done),
      .o_err(o_err), .i_err_clr(i_err_clr)
   );

   int n_cmp = 0;
   int n_fail = 0;
   int cyc = 0;
   int acc_cyc = 0;
   int rinv = 0;
   int rdy_mode = 0;
   bit stall = 1'b0;
   int phase = 0;

   typedef struct { int a; int b; } res_t;
   res_t exp_q[$];

   task automatic check(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Montgomery product with R = 2^12, so mont(767, b) = b.
   function automatic int mont(input int x, input int y);
      longint p;
      p = (longint'(x) * longint'(y)) % Q;
      return int'((p * longint'(rinv)) % Q);
   endfunction

   function automatic int au_func(input int x, input int y, input logic [1:0] op);
      if (op == 2'b10) return mont(x, y);
      if (op == 2'b01) return (x + y) % Q;
      return (x - y + Q) % Q;
   endfunction

   function automatic res_t bfly(input int a, input int b, input int z);
      res_t r;
      int t;
      t   = mont(z, b);
      r.a = (a + t) % Q;
      r.b = (a - t + Q) % Q;
      return r;
   endfunction

   // Arithmetic unit model: free-running 4-phase, result strobe on phase 3.
   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (!o_au_rstn) phase <= 0;
      else            phase <= (phase + 1) % 4;
   end
   assign au_c    = 12'(au_func(int'(o_au_a), int'(o_au_b), o_au_morb));
   assign au_done = (phase == 3) && !stall;

   initial begin
      forever begin
         @(posedge clk);
         #1;
         case (rdy_mode)
            0:       i_ready = 1'b1;
            1:       i_ready = 1'($urandom_range(0, 1));
            default: i_ready = 1'b0;
         endcase
      end
   end

   // Output monitor: result values, hold-while-stalled, ready/valid exclusivity.
   bit          pv = 1'b0, phs = 1'b0;
   logic [11:0] pa = '0, pb = '0;
   int          last_a = -1, last_b = -1;
   always @(negedge clk) begin
      if (rst) begin
         pv = 1'b0;
         phs = 1'b0;
      end else begin
         if (pv && !phs) begin
            check("hold_valid", int'(o_valid), 1);
            check("hold_a", int'(o_a), int'(pa));
            check("hold_b", int'(o_b), int'(pb));
         end
         if (o_valid) begin
            check("ready_low_while_valid", int'(o_ready), 0);
            if (!pv) begin
               check("latency_bound", ((cyc - acc_cyc) < 3*TMO+4) ? 1 : 0, 1);
               check("result_expected", (exp_q.size() > 0) ? 1 : 0, 1);
               if (exp_q.size() > 0) begin
                  check("model_a", int'(o_a), exp_q[0].a);
                  check("model_b", int'(o_b), exp_q[0].b);
               end
            end
            if (i_ready && exp_q.size() > 0) begin
               last_a = int'(o_a);
               last_b = int'(o_b);
               void'(exp_q.pop_front());
            end
         end
         pv  = o_valid;
         phs = o_valid && i_ready;
         pa  = o_a;
         pb  = o_b;
      end
   end

   task automatic send(input int a, input int b, input int z);
      bit ok;
      ok = 1'b0;
      i_a = 12'(a); i_b = 12'(b); i_zeta = 12'(z); i_valid = 1'b1;
      for (int n = 0; n < 300 && !ok; n++) begin
         @(negedge clk);
         ok = o_ready;
         @(posedge clk);
         #1;
      end
      i_valid = 1'b0;
      if (ok) begin
         exp_q.push_back(bfly(a, b, z));
         acc_cyc = cyc;
      end else begin
         check("accept_timeout", 0, 1);
      end
   endtask

   task automatic wait_valid();
      bit seen;
      seen = 1'b0;
      for (int n = 0; n < 3*TMO+8 && !seen; n++) begin
         @(negedge clk);
         seen = o_valid;
      end
      if (!seen) check("valid_timeout", 0, 1);
   endtask

   task automatic drain();
      bit done;
      done = 1'b0;
      for (int n = 0; n < 400 && !done; n++) begin
         @(negedge clk);
         done = (exp_q.size() == 0) && o_ready;
      end
      if (!done) check("drain_timeout", 0, 1);
      @(posedge clk);
      #1;
   endtask

   task automatic check_reset(input string tag);
      check({tag, "_ready"}, int'(o_ready), 1);
      check({tag, "_valid"}, int'(o_valid), 0);
      check({tag, "_oa"}, int'(o_a), 0);
      check({tag, "_ob"}, int'(o_b), 0);
      check({tag, "_au_a"}, int'(o_au_a), 0);
      check({tag, "_au_b"}, int'(o_au_b), 0);
      check({tag, "_morb"}, int'(o_au_morb), 2);
      check({tag, "_rstn"}, int'(o_au_rstn), 1);
      check({tag, "_err"}, int'(o_err), 0);
   endtask

   initial begin
      int n;
      bit hit;
      for (int i = 1; i < Q; i++) if ((4096 * i) % Q == 1) rinv = i;

      // Reset
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      check_reset("rst");
      @(posedge clk);
      #1;

      // Case 1: result held until consumer ready
      rdy_mode = 2;
      send(100, 200, 767);
      wait_valid();
      check("c1_a", int'(o_a), 300);
      check("c1_b", int'(o_b), 3229);
      check("c1_err", int'(o_err), 0);
      repeat (3) @(negedge clk);
      check("c1_still_valid", int'(o_valid), 1);
      @(posedge clk);
      #1;
      rdy_mode = 0;
      drain();

      // Case 2: add wraps
      send(3000, 1000, 767);
      wait_valid();
      check("c2_a", int'(o_a), 671);
      check("c2_b", int'(o_b), 2000);
      drain();

      // Case 3: zeta=0, back-to-back
      send(5, 1234, 0);
      send(1, 2, 767);
      check("c3_first_a", last_a, 5);
      check("c3_first_b", last_b, 5);
      drain();
      check("c3_second_a", last_a, 3);
      check("c3_second_b", last_b, 3328);

      // Case 4: 20-cycle stall with stray requests
      rdy_mode = 2;
      send(1111, 2222, 767);
      wait_valid();
      @(posedge clk);
      #1;
      i_a = 12'd7; i_b = 12'd8; i_zeta = 12'd9; i_valid = 1'b1;
      repeat (20) @(posedge clk);
      #1;
      i_valid = 1'b0;
      rdy_mode = 0;
      drain();
      repeat (4) @(negedge clk);
      check("c4_no_stray_valid", int'(o_valid), 0);
      check("c4_idle_ready", int'(o_ready), 1);
      @(posedge clk);
      #1;

      // Case 5: unit never answers
      stall = 1'b1;
      send(100, 200, 767);
      exp_q.delete();
      hit = 1'b0;
      n = 0;
      while (!hit && n < 3*TMO+8) begin
         @(negedge clk);
         n++;
         hit = o_err;
      end
      check("c5_err_set", int'(hit), 1);
      check("c5_not_early", (n > TMO) ? 1 : 0, 1);
      check("c5_au_rstn_pulse", int'(o_au_rstn), 0);
      check("c5_no_valid", int'(o_valid), 0);
      check("c5_back_idle", int'(o_ready), 1);
      stall = 1'b0;
      repeat (3) @(negedge clk);
      check("c5_sticky", int'(o_err), 1);
      check("c5_rstn_back", int'(o_au_rstn), 1);
      @(posedge clk);
      #1;
      i_err_clr = 1'b1;
      @(posedge clk);
      #1;
      i_err_clr = 1'b0;
      @(negedge clk);
      check("c5_err_clr", int'(o_err), 0);
      @(posedge clk);
      #1;
      send(100, 200, 767);
      wait_valid();
      check("c5_after_a", int'(o_a), 300);
      check("c5_after_b", int'(o_b), 3229);
      drain();

      // Case 6: reset in the add op
      send(2500, 3000, 1234);
      hit = 1'b0;
      for (int k = 0; k < 3*TMO && !hit; k++) begin
         @(negedge clk);
         hit = (o_au_morb == 2'b01);
      end
      check("c6_reached_add", int'(hit), 1);
      rst = 1'b1;
      #1;
      exp_q.delete();
      check_reset("c6_async");
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      check_reset("c6_post");
      @(posedge clk);
      #1;
      send(100, 200, 767);
      wait_valid();
      check("c6_after_a", int'(o_a), 300);
      check("c6_after_b", int'(o_b), 3229);
      drain();

      // Random traffic with random consumer back-pressure
      rdy_mode = 1;
      for (int r = 0; r < 40; r++) begin
         int za;
         za = ($urandom_range(0, 3) == 0) ? 767 : int'($urandom_range(0, Q-1));
         send(int'($urandom_range(0, Q-1)), int'($urandom_range(0, Q-1)), za);
      end
      drain();
      rdy_mode = 0;
      check("final_err", int'(o_err), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "global timeout");
   end

endmodule
`default_nettype wire
